// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and the saturating counter helper for the ctrl_pipe control pipeline.
package ctrl_pipe_pkg;
  localparam int DEF_STAGES = 3;
  localparam int DEF_WIDTH  = 16;
  localparam int CNT_W      = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Clear wins over increment; the count sticks at CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc,
                                               input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (clr)
      nxt = '0;
    else if (inc && (cnt != CNT_MAX))
      nxt = cnt + CNT_W'(1);
    return nxt;
  endfunction
endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: flush beats hold, hold beats load; bubbles and invalid inputs load zero.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_bubble,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (!i_hold) begin
      // An invalid word is stored as zero so out_ctrl never leaks stale bits.
      if (i_bubble || !i_valid) begin
        r_valid <= 1'b0;
        r_word  <= '0;
      end else begin
        r_valid <= 1'b1;
        r_word  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_word;
endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline with back-propagating hold, per-stage flush and optional performance
// counters (built only when CTRL_PIPE_PERF_EN is defined; otherwise counters read 0).
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_valid,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    perf_clr,
  output logic [STAGES*WIDTH-1:0] out_ctrl,
  output logic [STAGES-1:0]       out_valid,
  output logic [STAGES-1:0]       hold,
  output logic                    in_ready,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);
  logic [STAGES-1:0]       w_hold;
  logic [STAGES-1:0]       w_bubble;
  logic [STAGES-1:0]       w_valid;
  logic [STAGES*WIDTH-1:0] w_ctrl;

  // A stall anywhere downstream freezes every stage in front of it.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc       = acc | stall[i];
      w_hold[i] = acc;
    end
  end

  assign w_bubble[0] = 1'b0;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;
      if (g == 0) begin : g_head
        assign w_up_valid = in_valid;
        assign w_up_data  = in_ctrl;
      end else begin : g_body
        assign w_up_valid  = w_valid[g-1];
        assign w_up_data   = w_ctrl[(g-1)*WIDTH +: WIDTH];
        assign w_bubble[g] = w_hold[g-1] & ~w_hold[g];
      end

      ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush[g]),
        .i_hold  (w_hold[g]),
        .i_bubble(w_bubble[g]),
        .i_valid (w_up_valid),
        .i_data  (w_up_data),
        .o_valid (w_valid[g]),
        .o_data  (w_ctrl[g*WIDTH +: WIDTH])
      );
    end
  endgenerate

  assign out_ctrl  = w_ctrl;
  assign out_valid = w_valid;
  assign hold      = w_hold;
  assign in_ready  = ~w_hold[0];

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_any_bubble;
  logic             w_any_flush;

  // A bubble overridden by a flush on the same stage is not counted as a bubble.
  assign w_any_bubble = |(w_bubble & ~flush);
  assign w_any_flush  = |(flush & w_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_stall_cnt  <= sat_inc(r_stall_cnt, w_hold[0], perf_clr);
      r_bubble_cnt <= sat_inc(r_bubble_cnt, w_any_bubble, perf_clr);
      r_flush_cnt  <= sat_inc(r_flush_cnt, w_any_flush, perf_clr);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr;
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe (STAGES=3, WIDTH=16); counter expectations follow CTRL_PIPE_PERF_EN.
module tb_ctrl_pipe;
  localparam int S = 3;
  localparam int W = 16;
`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_ctrl;
  logic           in_valid;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic           perf_clr;
  logic [S*W-1:0] out_ctrl;
  logic [S-1:0]   out_valid;
  logic [S-1:0]   hold;
  logic           in_ready;
  logic [31:0]    stall_cnt, bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_w;

  ctrl_pipe #(.STAGES(S), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .out_ctrl(out_ctrl), .out_valid(out_valid), .hold(hold), .in_ready(in_ready),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_ctrl = '0; in_valid = 1'b0; stall = '0; flush = '0; perf_clr = 1'b0;
    #2;
    checks++;
    if (out_valid !== 3'b000 || out_ctrl !== '0) begin
      errors++; $display("FAIL reset_out: valid=%b ctrl=%h, want 0/0", out_valid, out_ctrl);
    end
    checks++;
    if (stall_cnt !== 0 || bubble_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt: %h %h %h, want 0", stall_cnt, bubble_cnt, flush_cnt);
    end
    stall = 3'b010;
    #1;
    checks++;
    if (hold !== 3'b011 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hold: hold=%b ready=%b, want 011/0", hold, in_ready);
    end
    stall = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [W-1:0] wv[3];
    wv[0] = 16'h0011; wv[1] = 16'h0022; wv[2] = 16'h0033;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      in_ctrl  = (c < 3) ? wv[c] : '0;
      #1;
      if (out_valid[2] && !hold[2]) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL lat_sb_extra: got %h, none expected", out_ctrl[2*W +: W]);
        end else begin
          exp_w = q.pop_front();
          if (out_ctrl[2*W +: W] !== exp_w) begin
            errors++; $display("FAIL lat_sb: got %h, want %h", out_ctrl[2*W +: W], exp_w);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_ctrl);
      cyc();
      if (c >= 2 && c <= 4) begin
        checks++;
        if (out_valid[2] !== 1'b1 || out_ctrl[2*W +: W] !== wv[c-2]) begin
          errors++; $display("FAIL lat_stage2_edge%0d: got %b/%h, want 1/%h", c + 1,
                             out_valid[2], out_ctrl[2*W +: W], wv[c-2]);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL lat_drain: %0d left, want 0", q.size()); end
  endtask

  task automatic test_stall();
    perf_clr = 1'b1; in_valid = 1'b1; in_ctrl = 16'hAAAA; stall = '0;
    #1; q.push_back(in_ctrl); cyc();
    perf_clr = 1'b0; in_ctrl = 16'hBBBB;
    #1; q.push_back(in_ctrl); cyc();
    checks++;
    if (out_ctrl[W +: W] !== 16'hAAAA) begin
      errors++; $display("FAIL stall_setup: stage1=%h, want aaaa", out_ctrl[W +: W]);
    end
    for (int c = 0; c < 2; c++) begin
      stall = 3'b010; in_ctrl = 16'hCCCC;
      #1;
      checks++;
      if (hold !== 3'b011 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold: hold=%b ready=%b, want 011/0", hold, in_ready);
      end
      cyc();
      checks++;
      if (out_ctrl[W +: W] !== 16'hAAAA || out_valid[2] !== 1'b0 || out_ctrl[2*W +: W] !== '0) begin
        errors++; $display("FAIL stall_freeze: s1=%h v2=%b s2=%h, want aaaa/0/0",
                           out_ctrl[W +: W], out_valid[2], out_ctrl[2*W +: W]);
      end
    end
    checks++;
    if (stall_cnt !== (PERF ? 32'd2 : 32'd0) || bubble_cnt !== (PERF ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL stall_cnt: stall=%0d bubble=%0d, want %0d/%0d", stall_cnt,
                         bubble_cnt, PERF ? 2 : 0, PERF ? 2 : 0);
    end
    stall = '0; in_valid = 1'b0; in_ctrl = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_valid[2] && !hold[2]) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stall_sb_extra: got %h, none expected", out_ctrl[2*W +: W]);
        end else begin
          exp_w = q.pop_front();
          if (out_ctrl[2*W +: W] !== exp_w) begin
            errors++; $display("FAIL stall_sb: got %h, want %h", out_ctrl[2*W +: W], exp_w);
          end
        end
      end
      cyc();
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d left, want 0", q.size()); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_ctrl = 16'h5555; stall = '0; flush = '0;
    #1; cyc();
    flush = 3'b001; stall = 3'b001; in_ctrl = 16'h6666;
    #1;
    checks++;
    if (hold[0] !== 1'b1) begin errors++; $display("FAIL flush_hold: hold=%b, want xx1", hold); end
    cyc();
    checks++;
    if (out_valid[0] !== 1'b0 || out_ctrl[0 +: W] !== '0) begin
      errors++; $display("FAIL flush_zero: v0=%b s0=%h, want 0/0", out_valid[0], out_ctrl[0 +: W]);
    end
    checks++;
    if (flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL flush_cnt: got %0d, want %0d", flush_cnt, PERF ? 1 : 0);
    end
    flush = '0;
    #1; cyc();
    checks++;
    if (out_valid[0] !== 1'b0 || out_ctrl[0 +: W] !== '0 || hold[0] !== 1'b1) begin
      errors++; $display("FAIL flush_held: v0=%b s0=%h hold=%b, want 0/0/xx1",
                         out_valid[0], out_ctrl[0 +: W], hold);
    end
    stall = '0; in_valid = 1'b0; in_ctrl = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid[2] && !hold[2]) begin
        checks++;
        errors++; $display("FAIL flush_leak: got %h, want nothing", out_ctrl[2*W +: W]);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [S-1:0] eh;
    for (int c = 0; c < 80; c++) begin
      if (c < 60) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_ctrl  = W'($urandom);
        for (int s = 0; s < S; s++) stall[s] = ($urandom_range(0, 3) == 0);
      end else begin
        in_valid = 1'b0; in_ctrl = '0; stall = '0;
      end
      #1;
      eh[2] = stall[2]; eh[1] = stall[1] | eh[2]; eh[0] = stall[0] | eh[1];
      checks++;
      if (hold !== eh || in_ready !== ~eh[0]) begin
        errors++; $display("FAIL b2b_hold: hold=%b ready=%b stall=%b, want %b/%b",
                           hold, in_ready, stall, eh, ~eh[0]);
      end
      if (out_valid[2] && !hold[2]) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_sb_extra: got %h, none expected", out_ctrl[2*W +: W]);
        end else begin
          exp_w = q.pop_front();
          if (out_ctrl[2*W +: W] !== exp_w) begin
            errors++; $display("FAIL b2b_sb: got %h, want %h", out_ctrl[2*W +: W], exp_w);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_ctrl);
      cyc();
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d left, want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; stall = '0; flush = '0;
    for (int c = 0; c < 3; c++) begin
      in_ctrl = W'((c + 1) * 16'h0101);
      #1; cyc();
    end
    checks++;
    if (out_valid !== 3'b111) begin errors++; $display("FAIL rmid_fill: valid=%b, want 111", out_valid); end
    #3; rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 3'b000 || out_ctrl !== '0) begin
      errors++; $display("FAIL rmid_async: valid=%b ctrl=%h, want 0/0", out_valid, out_ctrl);
    end
    #1; rst = 1'b0; in_ctrl = 16'h1234; in_valid = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 3'b001 || out_ctrl[0 +: W] !== 16'h1234) begin
      errors++; $display("FAIL rmid_reload: valid=%b s0=%h, want 001/1234", out_valid, out_ctrl[0 +: W]);
    end
    in_valid = 1'b0; in_ctrl = '0;
    #1; cyc(); cyc(); cyc();
  endtask

  task automatic test_counters();
    in_valid = 1'b0; in_ctrl = '0; flush = '0;
`ifdef CTRL_PIPE_PERF_EN
    stall = '0; perf_clr = 1'b1;
    #1; cyc();
    perf_clr = 1'b0;
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    stall = 3'b001;
    cyc(); cyc(); cyc();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL cnt_sat: got %h, want ffffffff", stall_cnt);
    end
    perf_clr = 1'b1;
    cyc();
    checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL cnt_clr: %h %h %h, want 0", stall_cnt, bubble_cnt, flush_cnt);
    end
`else
    stall = 3'b010;
    for (int c = 0; c < 10; c++) begin
      perf_clr = c[0];
      cyc();
    end
    checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL cnt_off: %h %h %h, want 0", stall_cnt, bubble_cnt, flush_cnt);
    end
`endif
    stall = '0; perf_clr = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter STAGES, default 3, range 2..8: number of control pipeline registers; stage 0 is the first after decode.
REQ-002 Parameter WIDTH, default 16, range 1..64: control bits carried per stage.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_ctrl  input  WIDTH  decoded control word offered to stage 0.
REQ-006 in_valid  input  1  in_ctrl holds a real instruction.
REQ-007 stall  input  STAGES  per-stage stall request; bit i means stage i cannot advance.
REQ-008 flush  input  STAGES  per-stage flush request; bit i squashes stage i.
REQ-009 perf_clr  input  1  synchronous clear of the performance counters.
REQ-010 out_ctrl  output  STAGES*WIDTH  stage i word at bits [i*WIDTH +: WIDTH].
REQ-011 out_valid  output  STAGES  per-stage valid.
REQ-012 hold  output  STAGES  effective per-stage hold.
REQ-013 in_ready  output  1  stage 0 accepts in_ctrl this cycle.
REQ-014 stall_cnt, bubble_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-015 hold[i] SHALL equal stall[i] OR hold[i+1]; hold[STAGES-1] = stall[STAGES-1]; purely combinational.
REQ-016 in_ready SHALL equal NOT hold[0].
REQ-017 Per stage, per edge, priority SHALL be: flush[i] -> word 0, valid 0; else hold[i] -> keep contents; else load from upstream.
REQ-018 Upstream for stage 0 SHALL be in_ctrl/in_valid; when in_valid=0, stage 0 SHALL load word 0, valid 0.
REQ-019 Upstream for stage i>0 SHALL be stage i-1; if hold[i-1]=1 and hold[i]=0, stage i SHALL load a bubble (word 0, valid 0).
REQ-020 Flush of a held stage SHALL still zero it; a flushed stage stays held if hold[i]=1.
REQ-021 Latency in_ctrl -> stage k output SHALL be k+1 cycles with no holds.
REQ-022 Hold at stage i SHALL freeze stages 0..i in the same cycle; stages >i keep advancing.
REQ-023 Invalid stages SHALL always present word 0 on out_ctrl.
REQ-024 stall_cnt SHALL increment on each cycle with hold[0]=1.
REQ-025 bubble_cnt SHALL increment once per cycle in which at least one bubble is inserted.
REQ-026 flush_cnt SHALL increment once per cycle in which any flush bit hits a valid stage.
REQ-027 Counters SHALL saturate at 0xFFFFFFFF; perf_clr SHALL zero them and take priority over increment.

Reset
REQ-028 rst=1 SHALL immediately force all out_ctrl, out_valid and counters to 0, independent of clk.
REQ-029 hold and in_ready SHALL follow their combinational definitions during reset.
REQ-030 Reset mid-operation SHALL discard all in-flight words; the first edge after release SHALL load normally.

Configuration
REQ-031 Macro CTRL_PIPE_PERF_EN defined: counters built per REQ-024..027.
REQ-032 Macro CTRL_PIPE_PERF_EN undefined: counter ports present, tied to 0, no counter flops; perf_clr ignored.

Structure
REQ-033 Package ctrl_pipe_pkg SHALL hold default STAGES/WIDTH, counter width 32 and saturation constant.
REQ-034 One sub-module ctrl_pipe_stage SHALL implement one register with flush/hold/bubble priority; instantiated STAGES times in a generate loop.

Verification
REQ-035 STAGES=3, no stall: in_ctrl 0x0011, 0x0022, 0x0033 on consecutive cycles -> stage 2 shows 0x0011 three cycles after the first is applied, then 0x0022, then 0x0033.
REQ-036 stall[1]=1 for 2 cycles with 0xAAAA in stage 1 -> hold=3'b011, in_ready=0, stage 1 keeps 0xAAAA, stage 2 gets two bubbles, stall_cnt=2, bubble_cnt=2.
REQ-037 flush[0]=1 and stall[0]=1 on the same edge with stage 0 valid -> stage 0 word 0, valid 0, stays held; flush_cnt=1.
REQ-038 rst pulsed between edges with all stages valid -> out_valid=0 and out_ctrl=0 immediately; next edge loads in_ctrl 0x1234 into stage 0.
REQ-039 Counter preloaded to 0xFFFFFFFE by forcing, 3 stall cycles -> holds 0xFFFFFFFF; perf_clr with stall on same cycle -> 0.
REQ-040 Build without CTRL_PIPE_PERF_EN, 10 stall cycles -> all counters read 0.
